id_hazard_ctrl: RTL and testbench
=================================

// Module: id_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage RV64 pipeline around the ID stage and its register file.
//  Tracks in-flight destination registers in EX/MEM/WB and decodes the instruction currently in IF/ID.
//  Drives stall (hold PC and IF/ID), the ID flush/bubble, the IF flush, EX operand-forward selects and the RF write enable.
//  Also keeps saturating stall/flush performance counters.
// PARAMETERS
//  FWD_EN  1   1: EX/MEM and MEM/WB forwarding enabled; 0: every RAW hazard stalls, fwd_a/fwd_b are always 0
//  CNT_W   32  width of the performance counters
// PORTS
//  clk          in   1      clock, all state updates on posedge
//  rst          in   1      reset, synchronous, active-low
//  id_inst      in   32     instruction held in IF/ID
//  id_valid     in   1      id_inst is a real instruction (0 = bubble)
//  branch_taken in   1      EX resolved a taken branch/jump this cycle
//  mem_stall    in   1      data memory busy; freeze the whole pipeline
//  stall        out  1      hold PC and IF/ID (combinational)
//  flush_if     out  1      turn IF/ID into a bubble (combinational)
//  flush_id     out  1      ID inserts a NOP into ID/EX (combinational)
//  fwd_a        out  2      EX rs1 source, registered with ID/EX: 00 RF, 01 EX/MEM result, 10 MEM/WB result
//  fwd_b        out  2      EX rs2 source, same encoding as fwd_a
//  rf_we        out  1      WB-stage instruction writes rd (gates the RF write)
//  stall_cnt    out  CNT_W  cycles with stall=1 and mem_stall=0, saturating
//  flush_cnt    out  CNT_W  cycles with branch_taken honoured, saturating
// BEHAVIOUR
//  Decode of id_inst[6:0]:
//   uses_rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 0111011, 0011011
//   uses_rs2: 0110011, 0100011, 1100011, 0111011
//   writes_rd: 0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111, 0111011, 0011011, and rd!=0
//   is_load: 0000011
//   Unknown opcodes use no sources and write nothing.
//  Tracking entries EX, MEM, WB each hold {valid, rd[4:0], wr, ld}.
//  A source matches an entry when: the source is used, its index is nonzero, entry.valid & entry.wr, and entry.rd equals the index.
//  The RF writes on negedge, so a WB-entry match is never a hazard.
//  Hazard (hz), evaluated when id_valid=1:
//   FWD_EN=1: some source matches EX with EX.ld=1 (load-use).
//   FWD_EN=0: some source matches EX or MEM.
//  Priority, highest first:
//   1) rst=0: all entries invalid; fwd=00; counters=0. All outputs read 0.
//   2) mem_stall=1: stall=1, flush_if=0, flush_id=0. Entries, fwd and counters hold. branch_taken is ignored (EX re-presents it).
//   3) branch_taken=1: flush_if=1, flush_id=1, stall=0 (overrides hz). flush_cnt+1.
//   4) hz=1: stall=1, flush_id=1, flush_if=0. stall_cnt+1.
//   5) otherwise: all three outputs are 0.
//  Posedge update when not case 1 or 2:
//   WB<=MEM, MEM<=EX.
//   EX<=decoded ID if id_valid & ~flush_id, else invalid.
//  fwd_a/fwd_b update in the same condition:
//   01 if the source matches the current EX entry; else 10 if it matches the current MEM entry; else 00.
//   Forced to 00 when the issued slot is a bubble or FWD_EN=0.
//   EX match wins over MEM match (youngest producer).
//  rf_we = WB.valid & WB.wr (combinational from state). Stores, branches and rd=x0 never write.
//  Load-use costs exactly 1 bubble. With FWD_EN=0, a RAW on an EX producer costs 2 bubbles, and on a MEM producer 1.
//  Counters saturate at all-ones and do not wrap.
//  Reset asserted mid-stall: the next cycle starts clean with no residual stall.
// TESTING
//  add x5,x1,x2 issued, then sub x6,x5,x3 in ID -> stall=0, next cycle fwd_a=01, fwd_b=00.
//  ld x5,0(x1), then add x6,x5,x5 -> 1 cycle stall=1, flush_id=1; then issue with fwd_a=fwd_b=10; stall_cnt=1.
//  addi x0,x1,1, then add x6,x0,x0 -> no stall, fwd 00/00, rf_we=0 when addi reaches WB.
//  Load-use pending and branch_taken=1 in the same cycle -> flush_if=1, flush_id=1, stall=0; flush_cnt=1, stall_cnt=0.
//  mem_stall=1 for 3 cycles with sd in WB -> rf_we=0 held, stall=1, entries and counters frozen; resumes unchanged.
//  FWD_EN=0: add x5, then add x6,x5,x1 -> stall 2 cycles, then fwd=00. Reset low during cycle 1 -> stall=0 after release.

Source files
------------

// File: rtl/id_hazard_ctrl_if.sv
// rtl/id_hazard_ctrl_if.sv - ID-stage hazard controller signal bundle
interface id_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      id_inst;
   logic             id_valid;
   logic             branch_taken;
   logic             mem_stall;
   logic             stall;
   logic             flush_if;
   logic             flush_id;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic             rf_we;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_inst, id_valid, branch_taken, mem_stall,
      input  stall, flush_if, flush_id, fwd_a, fwd_b, rf_we, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_inst, id_valid, branch_taken, mem_stall,
      output stall, flush_if, flush_id, fwd_a, fwd_b, rf_we, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - RV64 ID-stage hazard, forwarding and RF write-enable controller
module id_hazard_ctrl #(
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 32
) (
   input  logic            clk,
   input  logic            rst,
   id_hazard_ctrl_if.slave bus
);
   // One in-flight pipeline slot: valid, destination, writes-rd, is-load.
   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } entry_t;

   localparam logic             FWD     = (FWD_EN != 0);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   entry_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   logic [6:0] opc;
   logic [4:0] rs1, rs2, rd;
   logic       use_rs1, use_rs2, wr_op, ld_op;
   entry_t     dec;
   logic       a_ex, a_mem, b_ex, b_mem;
   logic       hz;
   logic       stall_c, flush_if_c, flush_id_c;
   logic       issue;

   assign opc = bus.id_inst[6:0];
   assign rd  = bus.id_inst[11:7];
   assign rs1 = bus.id_inst[19:15];
   assign rs2 = bus.id_inst[24:20];

   function automatic logic src_match(input logic used, input logic [4:0] idx, input entry_t e);
      return used && (idx != 5'd0) && e.v && e.wr && (e.rd == idx);
   endfunction

   // Decode the IF/ID opcode into source usage, destination write and load flags.
   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      wr_op   = 1'b0;
      ld_op   = 1'b0;
      case (opc)
         7'b0110011, 7'b0111011: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            wr_op   = 1'b1;
         end
         7'b0010011, 7'b0011011, 7'b1100111: begin
            use_rs1 = 1'b1;
            wr_op   = 1'b1;
         end
         7'b0000011: begin
            use_rs1 = 1'b1;
            wr_op   = 1'b1;
            ld_op   = 1'b1;
         end
         7'b0100011, 7'b1100011: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         7'b1101111, 7'b0110111, 7'b0010111: begin
            wr_op = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // rd=x0 never counts as a write, so it can never create a dependency.
   assign dec = {1'b1, rd, wr_op & (rd != 5'd0), ld_op};

   assign a_ex  = src_match(use_rs1, rs1, ex_q);
   assign a_mem = src_match(use_rs1, rs1, mem_q);
   assign b_ex  = src_match(use_rs2, rs2, ex_q);
   assign b_mem = src_match(use_rs2, rs2, mem_q);

   // Hazard: load-use with forwarding, any EX/MEM producer without it. WB matches are safe (negedge RF write).
   always_comb begin
      hz = 1'b0;
      if (bus.id_valid) begin
         if (FWD) begin
            hz = (a_ex | b_ex) & ex_q.ld;
         end else begin
            hz = a_ex | b_ex | a_mem | b_mem;
         end
      end
   end

   // Pipeline control priority: memory freeze, then taken branch, then RAW hazard.
   always_comb begin
      stall_c    = 1'b0;
      flush_if_c = 1'b0;
      flush_id_c = 1'b0;
      if (bus.mem_stall) begin
         stall_c = 1'b1;
      end else if (bus.branch_taken) begin
         flush_if_c = 1'b1;
         flush_id_c = 1'b1;
      end else if (hz) begin
         stall_c    = 1'b1;
         flush_id_c = 1'b1;
      end
   end

   // Next state: advance the tracking entries, forward selects and counters unless memory freezes the pipe.
   always_comb begin
      ex_d        = ex_q;
      mem_d       = mem_q;
      wb_d        = wb_q;
      fwd_a_d     = fwd_a_q;
      fwd_b_d     = fwd_b_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      issue       = bus.id_valid & ~flush_id_c;
      if (!bus.mem_stall) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         ex_d  = issue ? dec : '0;
         fwd_a_d = 2'b00;
         fwd_b_d = 2'b00;
         if (issue && FWD) begin
            // The youngest producer wins when both EX and MEM hold the register.
            if (a_ex) begin
               fwd_a_d = 2'b01;
            end else if (a_mem) begin
               fwd_a_d = 2'b10;
            end
            if (b_ex) begin
               fwd_b_d = 2'b01;
            end else if (b_mem) begin
               fwd_b_d = 2'b10;
            end
         end
         if (flush_if_c && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
         end
         if (stall_c && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         fwd_a_q     <= 2'b00;
         fwd_b_q     <= 2'b00;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // While reset is held every output reads zero, including state-derived ones.
   assign bus.stall     = rst & stall_c;
   assign bus.flush_if  = rst & flush_if_c;
   assign bus.flush_id  = rst & flush_id_c;
   assign bus.fwd_a     = rst ? fwd_a_q : 2'b00;
   assign bus.fwd_b     = rst ? fwd_b_q : 2'b00;
   assign bus.rf_we     = rst & wb_q.v & wb_q.wr;
   assign bus.stall_cnt = rst ? stall_cnt_q : '0;
   assign bus.flush_cnt = rst ? flush_cnt_q : '0;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - self-checking bench for id_hazard_ctrl
module tb_id_hazard_ctrl;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_hazard_ctrl_if #(.CNT_W(32)) bus0 ();
   id_hazard_ctrl_if #(.CNT_W(4))  bus1 ();

   id_hazard_ctrl #(.FWD_EN(1), .CNT_W(32)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   id_hazard_ctrl #(.FWD_EN(0), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   // Reference: the last three issued instruction words (EX, MEM, WB) per instance.
   logic [31:0] p_inst [2][3];
   logic        p_v    [2][3];
   logic [1:0]  m_fa [2];
   logic [1:0]  m_fb [2];
   longint      m_sc [2];
   longint      m_fc [2];
   longint      cmax [2];
   logic [6:0]  ops  [12];
   int          vectors = 0;
   int          fails   = 0;

   function automatic logic uses1(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                        7'b1100011, 7'b1100111, 7'b0111011, 7'b0011011};
   endfunction

   function automatic logic uses2(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0100011, 7'b1100011, 7'b0111011};
   endfunction

   function automatic logic writes(input logic [31:0] inst);
      return (inst[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111, 7'b1100111,
                                7'b0110111, 7'b0010111, 7'b0111011, 7'b0011011})
             && (inst[11:7] != 5'd0);
   endfunction

   // Depth of the youngest in-flight writer of idx: 0=EX, 1=MEM, 2=WB, 3=none.
   function automatic int youngest(input int k, input logic [4:0] idx);
      for (int j = 0; j < 3; j++) begin
         if (p_v[k][j] && writes(p_inst[k][j]) && (p_inst[k][j][11:7] == idx)) return j;
      end
      return 3;
   endfunction

   function automatic logic [1:0] enc(input int d);
      if (d == 0) return 2'b01;
      if (d == 1) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
      return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), op};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic [31:0] inst, input logic v, input logic br, input logic ms);
      logic        o_st [2], o_fi [2], o_fd [2], o_we [2];
      logic [1:0]  o_fa [2], o_fb [2];
      logic [31:0] o_sc [2], o_fc [2];
      rst               = r;
      bus0.id_inst      = inst;
      bus0.id_valid     = v;
      bus0.branch_taken = br;
      bus0.mem_stall    = ms;
      bus1.id_inst      = inst;
      bus1.id_valid     = v;
      bus1.branch_taken = br;
      bus1.mem_stall    = ms;
      @(negedge clk);
      o_st[0] = bus0.stall;    o_st[1] = bus1.stall;
      o_fi[0] = bus0.flush_if; o_fi[1] = bus1.flush_if;
      o_fd[0] = bus0.flush_id; o_fd[1] = bus1.flush_id;
      o_we[0] = bus0.rf_we;    o_we[1] = bus1.rf_we;
      o_fa[0] = bus0.fwd_a;    o_fa[1] = bus1.fwd_a;
      o_fb[0] = bus0.fwd_b;    o_fb[1] = bus1.fwd_b;
      o_sc[0] = bus0.stall_cnt; o_sc[1] = {28'b0, bus1.stall_cnt};
      o_fc[0] = bus0.flush_cnt; o_fc[1] = {28'b0, bus1.flush_cnt};
      for (int k = 0; k < 2; k++) begin
         automatic logic fw = (k == 0);
         automatic int   d1 = 3;
         automatic int   d2 = 3;
         automatic logic hz, e_st, e_fi, e_fd, e_we, iss;
         if (uses1(inst[6:0]) && inst[19:15] != 5'd0) d1 = youngest(k, inst[19:15]);
         if (uses2(inst[6:0]) && inst[24:20] != 5'd0) d2 = youngest(k, inst[24:20]);
         if (fw) hz = v && (d1 == 0 || d2 == 0) && (p_inst[k][0][6:0] == OP_LD);
         else    hz = v && (d1 <= 1 || d2 <= 1);
         e_st = ms | (~br & hz);
         e_fi = ~ms & br;
         e_fd = ~ms & (br | hz);
         e_we = p_v[k][2] && writes(p_inst[k][2]);
         chk($sformatf("stall[%0d]", k),     32'(o_st[k]), r ? 32'(e_st) : 32'd0);
         chk($sformatf("flush_if[%0d]", k),  32'(o_fi[k]), r ? 32'(e_fi) : 32'd0);
         chk($sformatf("flush_id[%0d]", k),  32'(o_fd[k]), r ? 32'(e_fd) : 32'd0);
         chk($sformatf("rf_we[%0d]", k),     32'(o_we[k]), r ? 32'(e_we) : 32'd0);
         chk($sformatf("fwd_a[%0d]", k),     32'(o_fa[k]), r ? 32'(m_fa[k]) : 32'd0);
         chk($sformatf("fwd_b[%0d]", k),     32'(o_fb[k]), r ? 32'(m_fb[k]) : 32'd0);
         chk($sformatf("stall_cnt[%0d]", k), o_sc[k],      r ? 32'(m_sc[k]) : 32'd0);
         chk($sformatf("flush_cnt[%0d]", k), o_fc[k],      r ? 32'(m_fc[k]) : 32'd0);
         if (!r) begin
            for (int j = 0; j < 3; j++) p_v[k][j] = 1'b0;
            m_fa[k] = 2'b00;
            m_fb[k] = 2'b00;
            m_sc[k] = 0;
            m_fc[k] = 0;
         end else if (!ms) begin
            iss     = v && !e_fd;
            m_fa[k] = (iss && fw) ? enc(d1) : 2'b00;
            m_fb[k] = (iss && fw) ? enc(d2) : 2'b00;
            p_inst[k][2] = p_inst[k][1]; p_v[k][2] = p_v[k][1];
            p_inst[k][1] = p_inst[k][0]; p_v[k][1] = p_v[k][0];
            p_inst[k][0] = inst;         p_v[k][0] = iss;
            if (br) begin
               if (m_fc[k] < cmax[k]) m_fc[k]++;
            end else if (hz) begin
               if (m_sc[k] < cmax[k]) m_sc[k]++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 3; j++) begin
            p_inst[k][j] = 32'd0;
            p_v[k][j]    = 1'b0;
         end
         m_fa[k] = 2'b00;
         m_fb[k] = 2'b00;
         m_sc[k] = 0;
         m_fc[k] = 0;
      end
      cmax[0] = 64'h0000_0000_FFFF_FFFF;
      cmax[1] = 15;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111,
              7'b0111011, 7'b0011011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1111111};

      // reset
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      // add x5,x1,x2 then sub x6,x5,x3: EX forward
      cyc(1'b1, mk(OP_R, 5, 1, 2), 1'b1, 1'b0, 1'b0);
      cyc(1'b1, mk(OP_R, 6, 5, 3), 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      // ld x5 then add x6,x5,x5: one load-use bubble then MEM/WB forward
      cyc(1'b1, mk(OP_LD, 5, 1, 0), 1'b1, 1'b0, 1'b0);
      repeat (2) cyc(1'b1, mk(OP_R, 6, 5, 5), 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      // addi x0 then add x6,x0,x0: no dependency, no RF write
      cyc(1'b1, mk(OP_I, 0, 1, 1), 1'b1, 1'b0, 1'b0);
      cyc(1'b1, mk(OP_R, 6, 0, 0), 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      // load-use pending with a taken branch in the same cycle
      cyc(1'b1, mk(OP_LD, 7, 1, 0), 1'b1, 1'b0, 1'b0);
      cyc(1'b1, mk(OP_R, 8, 7, 1), 1'b1, 1'b1, 1'b0);
      repeat (2) cyc(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      // store walks to WB, then memory freezes for three cycles
      cyc(1'b1, mk(OP_ST, 5, 1, 5), 1'b1, 1'b0, 1'b0);
      repeat (2) cyc(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, mk(OP_R, 9, 5, 1), 1'b1, 1'b1, 1'b1);
      cyc(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      // EX producer: two bubbles without forwarding
      cyc(1'b1, mk(OP_R, 5, 1, 2), 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, mk(OP_R, 6, 5, 1), 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      // reset asserted in the middle of a stall
      cyc(1'b1, mk(OP_R, 5, 1, 2), 1'b1, 1'b0, 1'b0);
      cyc(1'b1, mk(OP_R, 6, 5, 1), 1'b1, 1'b0, 1'b0);
      cyc(1'b0, mk(OP_R, 6, 5, 1), 1'b1, 1'b0, 1'b0);
      cyc(1'b1, mk(OP_R, 6, 5, 1), 1'b1, 1'b0, 1'b0);
      repeat (2) cyc(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      // randomized traffic over a small register set
      for (int n = 0; n < 800; n++) begin
         automatic logic [31:0] inst = $urandom;
         automatic logic        r    = ($urandom_range(0, 59) != 0);
         automatic logic        v    = ($urandom_range(0, 99) < 85);
         automatic logic        br   = ($urandom_range(0, 9) == 0);
         automatic logic        ms   = ($urandom_range(0, 9) == 0);
         inst[6:0]   = ops[$urandom_range(0, 11)];
         inst[11:7]  = 5'($urandom_range(0, 7));
         inst[19:15] = 5'($urandom_range(0, 7));
         inst[24:20] = 5'($urandom_range(0, 7));
         cyc(r, inst, v, br, ms);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
